// File: rtl/pc_fetch.sv
// Instruction-fetch / program-counter stage: holds the architectural PC, fetches
// over a req/ack port, presents the word to decode and steps the PC on commit.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] immediate,
  input  logic [31:0] rs1_data,
  input  logic        commit,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        err_misalign,
  output logic        err_bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_t;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;

  // All adds wrap modulo 2^32; jalr clears bit 0 before any alignment test.
  function automatic logic [31:0] calc_next_pc(
    input logic [1:0]  src,
    input logic [31:0] cur,
    input logic [31:0] imm,
    input logic [31:0] rs1
  );
    case (src)
      2'b00:   return cur + 32'd4;
      2'b10:   return (rs1 + imm) & ~32'd1;
      default: return cur + imm;
    endcase
  endfunction

  assign next_pc   = calc_next_pc(pcsource, pc, immediate, rs1_data);
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      inst         <= NOP_INST;
      inst_valid   <= 1'b0;
      imem_req     <= 1'b0;
      err_misalign <= 1'b0;
      err_bus      <= 1'b0;
      wait_cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= 8'd0;
        end
        FETCH: begin
          // An ack on the final allowed edge still wins over the timeout.
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            err_bus  <= 1'b1;
            imem_req <= 1'b0;
            state    <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (commit) begin
            pc         <= next_pc;
            inst_valid <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              state    <= FETCH;
              imem_req <= 1'b1;
              wait_cnt <= 8'd0;
            end else begin
              err_misalign <= 1'b1;
              state        <= HALT;
            end
          end
        end
        HALT: begin
          // Terminal until reset; pc keeps the faulting target.
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: vector table, hand-written corner sequences and a random
// run checked against an arithmetic next-PC model.
module tb_pc_fetch;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] immediate;
  logic [31:0] rs1_data;
  logic        commit;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        err_misalign;
  logic        err_bus;

  logic [1:0]  t_pcsource;
  logic [31:0] t_immediate;
  logic [31:0] t_rs1_data;
  logic        t_commit;
  logic [31:0] t_imem_addr;
  logic        t_imem_req;
  logic [31:0] t_imem_rdata;
  logic        t_imem_ack;
  logic [31:0] t_inst;
  logic        t_inst_valid;
  logic [31:0] t_pc;
  logic [31:0] t_pc_plus4;
  logic        t_err_misalign;
  logic        t_err_bus;

  always #5 clock = ~clock;

  pc_fetch dut (
    .clock(clock), .resetn(resetn), .pcsource(pcsource), .immediate(immediate),
    .rs1_data(rs1_data), .commit(commit), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc_plus4(pc_plus4), .err_misalign(err_misalign), .err_bus(err_bus)
  );

  pc_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut_to (
    .clock(clock), .resetn(resetn), .pcsource(t_pcsource), .immediate(t_immediate),
    .rs1_data(t_rs1_data), .commit(t_commit), .imem_addr(t_imem_addr), .imem_req(t_imem_req),
    .imem_rdata(t_imem_rdata), .imem_ack(t_imem_ack), .inst(t_inst), .inst_valid(t_inst_valid),
    .pc(t_pc), .pc_plus4(t_pc_plus4), .err_misalign(t_err_misalign), .err_bus(t_err_bus)
  );

  typedef struct {
    int          waits;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        tbl[11];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_next(input logic [1:0] src, input logic [31:0] cur,
                                           input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    if (src == 2'd0) return cur + 32'd4;
    if (src == 2'd2) begin
      t = rs1 + imm;
      return t - (t % 32'd2);
    end
    return cur + imm;
  endfunction

  // Reset asserted between edges; outputs must already be at reset values.
  task automatic do_reset();
    @(posedge clock); #1;
    resetn     = 1'b0;
    commit     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    #2;
    chk1("rst_req", imem_req, 1'b0);
    chk ("rst_pc", pc, 32'h0);
    chk ("rst_inst", inst, 32'h0000_0013);
    chk1("rst_valid", inst_valid, 1'b0);
    chk1("rst_err_mis", err_misalign, 1'b0);
    chk1("rst_err_bus", err_bus, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    model_pc = 32'h0;
    chk1("e0_req", imem_req, 1'b1);
  endtask

  task automatic fetch(input int waits);
    int req_cycles;
    req_cycles = 0;
    chk("fetch_addr", imem_addr, model_pc);
    for (int i = 0; i < waits; i++) begin
      if (imem_req) req_cycles++;
      imem_ack   = 1'b0;
      commit     = 1'($urandom);
      imem_rdata = $urandom;
      @(posedge clock); #1;
      chk1("wait_valid", inst_valid, 1'b0);
    end
    if (imem_req) req_cycles++;
    commit     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = mem_word(model_pc);
    @(posedge clock); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk ("req_cycles", 32'(req_cycles), 32'(waits + 1));
    chk ("inst", inst, mem_word(model_pc));
    chk1("inst_valid", inst_valid, 1'b1);
    chk1("hold_req", imem_req, 1'b0);
    chk ("hold_pc", pc, model_pc);
  endtask

  task automatic hold_commit(input logic [1:0] src, input logic [31:0] imm,
                             input logic [31:0] rs1, input logic stray, output logic halted);
    logic [31:0] exp;
    if (stray) begin
      imem_ack   = 1'b1;
      imem_rdata = ~mem_word(model_pc);
      @(posedge clock); #1;
      imem_ack = 1'b0;
      chk ("stray_ack_inst", inst, mem_word(model_pc));
      chk1("stray_ack_valid", inst_valid, 1'b1);
      chk1("stray_ack_req", imem_req, 1'b0);
    end
    chk("pc_plus4", pc_plus4, model_pc + 32'd4);
    pcsource  = src;
    immediate = imm;
    rs1_data  = rs1;
    commit    = 1'b1;
    @(posedge clock); #1;
    commit    = 1'b0;
    pcsource  = 2'($urandom);
    immediate = $urandom;
    rs1_data  = $urandom;
    exp      = ref_next(src, model_pc, imm, rs1);
    model_pc = exp;
    chk ("commit_pc", pc, exp);
    chk1("commit_valid", inst_valid, 1'b0);
    if (exp % 32'd4 == 32'd0) begin
      halted = 1'b0;
      chk1("commit_req", imem_req, 1'b1);
      chk1("commit_err_mis", err_misalign, 1'b0);
    end else begin
      halted = 1'b1;
      chk1("mis_req", imem_req, 1'b0);
      chk1("mis_err", err_misalign, 1'b1);
      chk1("mis_no_bus", err_bus, 1'b0);
    end
  endtask

  initial begin
    logic halted;
    logic [1:0]  r_src;
    logic [31:0] r_imm, r_rs1;

    tbl[0]  = '{0, 2'd0, 32'h0,         32'h0,    32'h0000_0004};
    tbl[1]  = '{0, 2'd0, 32'h0,         32'h0,    32'h0000_0008};
    tbl[2]  = '{3, 2'd0, 32'h0,         32'h0,    32'h0000_000C};
    tbl[3]  = '{1, 2'd3, 32'h0000_00F4, 32'h0,    32'h0000_0100};
    tbl[4]  = '{0, 2'd1, 32'hFFFF_FFF0, 32'h0,    32'h0000_00F0};
    tbl[5]  = '{2, 2'd3, 32'h0000_0800, 32'h0,    32'h0000_08F0};
    tbl[6]  = '{0, 2'd2, 32'h0000_0005, 32'h1000, 32'h0000_1004};
    tbl[7]  = '{0, 2'd1, 32'hFFFF_FFF8, 32'h0,    32'h0000_0FFC};
    tbl[8]  = '{1, 2'd3, 32'hFFFF_F000, 32'h0,    32'hFFFF_FFFC};
    tbl[9]  = '{0, 2'd0, 32'h0,         32'h0,    32'h0000_0000};
    tbl[10] = '{0, 2'd2, 32'h0000_0004, 32'h2003, 32'h0000_2006};

    resetn = 1'b1; pcsource = 2'd0; immediate = 32'h0; rs1_data = 32'h0;
    commit = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    t_pcsource = 2'd0; t_immediate = 32'h0; t_rs1_data = 32'h0;
    t_commit = 1'b0; t_imem_ack = 1'b0; t_imem_rdata = 32'h0;
    model_pc = 32'h0;

    // Timeout instance: no ack ever, error after the 4th FETCH edge.
    do_reset();
    chk1("to_req_e0", t_imem_req, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      chk1("to_err_bus", t_err_bus, k == 4);
      chk1("to_req", t_imem_req, k != 4);
    end
    chk1("to_no_mis", t_err_misalign, 1'b0);
    chk1("to_valid", t_inst_valid, 1'b0);

    // Directed table, ending with a misaligned jalr.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      fetch(tbl[i].waits);
      hold_commit(tbl[i].src, tbl[i].imm, tbl[i].rs1, i[0], halted);
      chk ("tbl_pc", pc, tbl[i].exp_pc);
      chk1("tbl_halt", halted, i == 10);
    end

    // HALT ignores commits and acks.
    for (int k = 0; k < 4; k++) begin
      commit = 1'b1; imem_ack = 1'b1; pcsource = 2'd0; imem_rdata = $urandom;
      @(posedge clock); #1;
      chk1("halt_req", imem_req, 1'b0);
      chk1("halt_valid", inst_valid, 1'b0);
      chk ("halt_pc", pc, 32'h0000_2006);
      chk1("halt_err_mis", err_misalign, 1'b1);
      chk1("halt_err_bus", err_bus, 1'b0);
    end
    commit = 1'b0; imem_ack = 1'b0;

    // Reset while a fetch is outstanding at a non-zero pc.
    do_reset();
    fetch(0);
    hold_commit(2'd0, 32'h0, 32'h0, 1'b0, halted);
    chk1("pre_rst_req", imem_req, 1'b1);
    do_reset();

    // Random run against the next-PC model.
    for (int n = 0; n < 60; n++) begin
      fetch(int'($urandom_range(0, 3)));
      r_src = 2'($urandom);
      r_imm = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      r_rs1 = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      hold_commit(r_src, r_imm, r_rs1, 1'($urandom), halted);
      if (halted) do_reset();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
